jt1943_sdram_arbiter: RTL and testbench
=======================================

Name: jt1943_sdram_arbiter

Overview:
- Shares the single game-side SDRAM read port among SLOTS ROM requesters: main CPU, sound CPU, char, scroll and objects.
- The board SDRAM controller provides the port: sdram_req/sdram_addr/sdram_ack/data_rdy/data_read.
- Each slot has a one-entry data latch, so repeated reads of the same word return without an SDRAM access.
- Sits inside the game module between the per-layer ROM address generators and the board SDRAM controller; also drives refresh_en.

Parameters:
- SLOTS, 4, number of requesters (2..8).
- AW, 22, SDRAM word address width.
- DW, 32, data width returned per access.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- loop_rst  in  1  synchronous flush from the board: abort the transaction and invalidate all latches.
- downloading  in  1  ROM download in progress: no new requests issued.
- slot_cs  in  SLOTS  per-slot read request, level held until slot_ok.
- slot_addr  in  SLOTS*AW  packed per-slot word addresses; slot i occupies bits [i*AW +: AW].
- slot_ok  out  SLOTS  slot data valid for the current slot_addr.
- slot_dout  out  SLOTS*DW  packed per-slot latched data.
- sdram_req  out  1  request to the SDRAM controller.
- sdram_addr  out  AW  address of the current request.
- sdram_ack  in  1  controller accepted the request (one-cycle pulse).
- data_rdy  in  1  data_read is valid (one-cycle pulse).
- data_read  in  DW  SDRAM read data.
- refresh_en  out  1  controller may refresh.

Behaviour:
- Reset values (rst high, asynchronous):
  - sdram_req=0, sdram_addr=0, refresh_en=1, state=IDLE, rr_ptr=0.
  - All latch valid bits=0, all slot_dout=0.
  - slot_ok=0.
- Per-slot latch: tag[AW], data[DW], valid.
- Hit: hit[i] = valid[i] & (tag[i]==slot_addr[i]).
- slot_ok[i] = slot_cs[i] & hit[i], combinational from registered latch state. A changed address therefore drops slot_ok in the same cycle. Zero-cycle latency on a hit.
- Pending: pend[i] = slot_cs[i] & ~hit[i].
- State machine:
  - IDLE:
    - If ~downloading and any pend bit is set, grant the first pending slot found searching circularly from rr_ptr.
    - Latch gnt index, sdram_addr=slot_addr[gnt], sdram_req=1. Next: WAIT_ACK.
    - refresh_en=1 only in IDLE with no pend.
  - WAIT_ACK:
    - Hold sdram_req/sdram_addr.
    - On sdram_ack: sdram_req=0 on the next cycle, rr_ptr=gnt+1 (mod SLOTS).
    - If data_rdy is also high in the same cycle, take the WAIT_RDY completion path immediately and go to IDLE. Otherwise go to WAIT_RDY.
  - WAIT_RDY:
    - On data_rdy: data[gnt]=data_read, tag[gnt]=the issued sdram_addr (not the current slot_addr), valid[gnt]=1. Next: IDLE.
    - If the slot address moved during the access, the write still occurs. The slot is then a miss and is re-requested later.
- Grant fairness: rotating pointer. With all slots pending continuously, each slot is served once every SLOTS transactions.
- An issued request is never cancelled by slot_cs dropping; it completes and fills the latch.
- Back-to-back: the IDLE→WAIT_ACK re-issue takes 1 cycle after completion. No request is issued in the completion cycle.
- loop_rst (synchronous, priority over all state logic):
  - state=IDLE, sdram_req=0, all valid=0.
  - rr_ptr is unchanged.
  - A data_rdy arriving after the abort is ignored.
- downloading=1:
  - No new grant in IDLE; an in-flight transaction completes normally.
  - All valid bits are cleared on the falling edge of downloading, because ROM contents changed.
- rst asserted mid-transaction: immediate return to reset values. The controller side is reset by the same board reset.

Decomposition:
- Shared package jt1943_sdram_pkg:
  - state enum {IDLE, WAIT_ACK, WAIT_RDY}.
  - localparam for the slot index width, $clog2(SLOTS).
- One natural sub-module: jt1943_slot_latch (tag/data/valid plus hit compare), instantiated SLOTS times via generate.
- The arbiter FSM and rotating priority encoder stay in the top module.

Test Plan:
- Single miss:
  - Stimulus: slot_cs[1]=1, addr1=22'h012345; controller acks 2 cycles after req, data_rdy 4 cycles later with 32'hDEADBEEF.
  - Required: sdram_addr=22'h012345 while req=1; slot_ok[1] rises the cycle after data_rdy; slot_dout[1]=32'hDEADBEEF.
- Hit:
  - Stimulus: re-assert slot 1 with the same addr after the single-miss fill.
  - Required: slot_ok[1]=1 in the same cycle; sdram_req stays 0; refresh_en stays 1.
- Round-robin:
  - Stimulus: all 4 slots miss continuously with distinct addresses.
  - Required: grant order 0,1,2,3, then 0 again once slot 0's address changes.
- Address change mid-access:
  - Stimulus: slot 2 requests A=22'h100; addr changes to 22'h200 before data_rdy.
  - Required: latch tag=22'h100; slot_ok[2]=0; a second request is issued for 22'h200.
- loop_rst during WAIT_RDY:
  - Stimulus: assert loop_rst during WAIT_RDY; data_rdy arrives after the abort.
  - Required: sdram_req=0, all slot_ok=0, the late data_rdy leaves all latches invalid, and a fresh request follows.
- downloading:
  - Stimulus: pending slot 3 while downloading=1, then downloading falls.
  - Required: no sdram_req while downloading=1; previously valid latches read invalid afterwards; slot 3 is served after downloading falls.

Source files
------------

// File: rtl/jt1943_sdram_pkg.sv
// Shared types for the jt1943 SDRAM read-port arbiter.
package jt1943_sdram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_RDY
  } state_e;

  // Slot index width, sized for the largest supported SLOTS (8).
  localparam int unsigned MAX_SLOTS = 8;
  localparam int unsigned IDX_W     = $clog2(MAX_SLOTS);

  typedef logic [IDX_W-1:0] slot_idx_t;

  // Successor of a slot index, wrapping at the configured slot count.
  function automatic slot_idx_t next_slot(slot_idx_t cur, int unsigned slots);
    logic [IDX_W:0] n;
    n = {1'b0, cur} + 1'b1;
    if (n >= (IDX_W+1)'(slots)) n = '0;
    return n[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/jt1943_slot_latch.sv
// One-entry read cache for a single requester: tag, data, valid and hit compare.
module jt1943_slot_latch #(
  parameter int AW = 22,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          wr_i,
  input  logic [AW-1:0] wr_tag_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic          hit_o,
  output logic [DW-1:0] dout_o
);

  logic [AW-1:0] tag_q;
  logic [DW-1:0] data_q;
  logic          valid_q;

  // Fill on write; a flush only drops valid and wins over a simultaneous fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: tag and data are reset too, so slot_dout reads zero after reset
      // instead of whatever the flops powered up with.
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (wr_i) begin
        tag_q  <= wr_tag_i;
        data_q <= wr_data_i;
      end
      if (clr_i)     valid_q <= 1'b0;
      else if (wr_i) valid_q <= 1'b1;
    end
  end

  assign hit_o  = valid_q && (tag_q == rd_addr_i);
  assign dout_o = data_q;

endmodule

// File: rtl/jt1943_sdram_arbiter.sv
// Round-robin arbiter sharing the game SDRAM read port among ROM requesters.
module jt1943_sdram_arbiter
  import jt1943_sdram_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AW    = 22,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                loop_rst,
  input  logic                downloading,
  input  logic [SLOTS-1:0]    slot_cs,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [SLOTS*DW-1:0] slot_dout,
  output logic                sdram_req,
  output logic [AW-1:0]       sdram_addr,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [DW-1:0]       data_read,
  output logic                refresh_en
);

  state_e        state_q, state_d;
  slot_idx_t     gnt_q, gnt_d;
  slot_idx_t     rr_q, rr_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          dl_q;
  logic          fill;
  logic          flush;

  logic [SLOTS-1:0]     hit;
  logic [SLOTS-1:0]     pend;
  logic [MAX_SLOTS-1:0] pend_w;
  logic [AW-1:0]        addr_arr [MAX_SLOTS];
  slot_idx_t            pick;
  logic                 found;

  // Loop reset and the end of a ROM download both invalidate every latch.
  assign flush = loop_rst || (dl_q && !downloading);

  for (genvar i = 0; i < MAX_SLOTS; i++) begin : g_slot
    if (i < SLOTS) begin : g_used
      assign addr_arr[i] = slot_addr[i*AW +: AW];

      jt1943_slot_latch #(.AW(AW), .DW(DW)) u_latch (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (flush),
        .wr_i     (fill && (gnt_q == slot_idx_t'(i))),
        .wr_tag_i (addr_q),
        .wr_data_i(data_read),
        .rd_addr_i(slot_addr[i*AW +: AW]),
        .hit_o    (hit[i]),
        .dout_o   (slot_dout[i*DW +: DW])
      );
    end else begin : g_pad
      assign addr_arr[i] = '0;
    end
  end

  assign slot_ok    = slot_cs & hit;
  assign pend       = slot_cs & ~hit;
  assign pend_w     = MAX_SLOTS'(pend);
  assign refresh_en = (state_q == IDLE) && (pend == '0);

  // Rotating priority: first pending slot at or after rr_q, wrapping at SLOTS.
  always_comb begin
    logic [IDX_W:0] sum;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < SLOTS; k++) begin
      sum = {1'b0, rr_q} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(SLOTS)) sum = sum - (IDX_W+1)'(SLOTS);
      if (!found && pend_w[sum[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = sum[IDX_W-1:0];
      end
    end
  end

  // Transaction FSM: issue, wait for accept, wait for data, fill the latch.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    req_d   = req_q;
    addr_d  = addr_q;
    fill    = 1'b0;
    if (loop_rst) begin
      state_d = IDLE;
      req_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // One idle cycle after a download ends lets the flush land first.
          if (!downloading && !dl_q && found) begin
            gnt_d   = pick;
            addr_d  = addr_arr[pick];
            req_d   = 1'b1;
            state_d = WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (sdram_ack) begin
            req_d = 1'b0;
            rr_d  = next_slot(gnt_q, SLOTS);
            if (data_rdy) begin
              fill    = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = WAIT_RDY;
            end
          end
        end
        WAIT_RDY: begin
          if (data_rdy) begin
            fill    = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and request registers; dl_q remembers downloading for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      dl_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      dl_q    <= downloading;
    end
  end

  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;

endmodule

// File: tb/tb_jt1943_sdram_arbiter.sv
// Randomised bench for jt1943_sdram_arbiter against a transaction-level model.
module tb_jt1943_sdram_arbiter;

  localparam int SLOTS = 4;
  localparam int AW    = 22;
  localparam int DW    = 32;

  logic                clk = 1'b0;
  logic                rst, loop_rst, downloading;
  logic [SLOTS-1:0]    slot_cs;
  logic [SLOTS*AW-1:0] slot_addr;
  logic [SLOTS-1:0]    slot_ok;
  logic [SLOTS*DW-1:0] slot_dout;
  logic                sdram_req;
  logic [AW-1:0]       sdram_addr;
  logic                sdram_ack, data_rdy;
  logic [DW-1:0]       data_read;
  logic                refresh_en;

  jt1943_sdram_arbiter #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .loop_rst   (loop_rst),
    .downloading(downloading),
    .slot_cs    (slot_cs),
    .slot_addr  (slot_addr),
    .slot_ok    (slot_ok),
    .slot_dout  (slot_dout),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .data_rdy   (data_rdy),
    .data_read  (data_read),
    .refresh_en (refresh_en)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requester addresses
  logic [AW-1:0] a [SLOTS];

  // Reference model: one outstanding transaction plus a cache line per slot
  bit            m_busy, m_acked, m_dl_prev;
  int            m_slot, m_rr;
  logic [AW-1:0] m_addr;
  bit            m_valid [SLOTS];
  logic [AW-1:0] m_tag   [SLOTS];
  logic [DW-1:0] m_data  [SLOTS];

  // Controller model and its knobs (-1 selects a random delay)
  int            c_ack_cnt, c_rdy_delay, c_rdy_cnt;
  logic [DW-1:0] c_data;
  int            k_ack, k_rdy;
  bit            k_force;
  logic [DW-1:0] k_data;

  // Addresses the DUT issued, in order
  logic [AW-1:0] iss_q [$];
  bit            prev_req;

  task automatic model_reset();
    m_busy = 0; m_acked = 0; m_dl_prev = 0; m_slot = 0; m_rr = 0; m_addr = '0;
    for (int i = 0; i < SLOTS; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_data[i] = '0;
    end
    c_ack_cnt = 0; c_rdy_delay = 0; c_rdy_cnt = -1; c_data = '0; prev_req = 0;
  endtask

  function automatic logic [SLOTS*AW-1:0] pack_addr();
    logic [SLOTS*AW-1:0] r;
    for (int i = 0; i < SLOTS; i++) r[i*AW +: AW] = a[i];
    return r;
  endfunction

  function automatic bit settled();
    if (m_busy) return 0;
    for (int i = 0; i < SLOTS; i++)
      if (slot_cs[i] && !(m_valid[i] && m_tag[i] == a[i])) return 0;
    return 1;
  endfunction

  task automatic drive();
    slot_addr = pack_addr();
    sdram_ack = m_busy && !m_acked && (c_ack_cnt == 0);
    data_rdy  = (c_rdy_cnt == 0) || (sdram_ack && c_rdy_delay == 0);
    data_read = c_data;
  endtask

  // One clock: drive, compare against the model, advance the model, step.
  task automatic tick();
    logic [SLOTS-1:0] exp_ok, pnd;
    bit hit, exp_req, found;
    drive();
    #1;
    for (int i = 0; i < SLOTS; i++) begin
      hit       = m_valid[i] && (m_tag[i] == a[i]);
      exp_ok[i] = slot_cs[i] && hit;
      pnd[i]    = slot_cs[i] && !hit;
    end
    exp_req = m_busy && !m_acked;
    check("slot_ok", 64'(slot_ok), 64'(exp_ok));
    for (int i = 0; i < SLOTS; i++)
      check("slot_dout", 64'(slot_dout[i*DW +: DW]), 64'(m_data[i]));
    check("sdram_req", 64'(sdram_req), 64'(exp_req));
    if (exp_req) check("sdram_addr", 64'(sdram_addr), 64'(m_addr));
    check("refresh_en", 64'(refresh_en), 64'(!m_busy && pnd == '0));
    if (sdram_req && !prev_req) iss_q.push_back(sdram_addr);
    prev_req = sdram_req;

    // controller counters
    if (m_busy && !m_acked && !sdram_ack && c_ack_cnt > 0) c_ack_cnt--;
    if (sdram_ack)           c_rdy_cnt = (c_rdy_delay == 0) ? -1 : c_rdy_delay - 1;
    else if (c_rdy_cnt > 0)  c_rdy_cnt--;
    else if (c_rdy_cnt == 0) c_rdy_cnt = -1;

    // arbiter behaviour
    if (loop_rst) begin
      m_busy = 0;
      for (int i = 0; i < SLOTS; i++) m_valid[i] = 0;
    end else begin
      if (m_busy) begin
        if (sdram_ack) begin
          m_acked = 1;
          m_rr    = (m_slot + 1) % SLOTS;
        end
        if (data_rdy && m_acked) begin
          m_tag[m_slot]   = m_addr;
          m_data[m_slot]  = data_read;
          m_valid[m_slot] = 1;
          m_busy          = 0;
        end
      end else if (!downloading && !m_dl_prev && pnd != '0) begin
        found = 0;
        for (int k = 0; k < SLOTS; k++) begin
          int s;
          s = (m_rr + k) % SLOTS;
          if (!found && pnd[s]) begin
            found  = 1;
            m_slot = s;
          end
        end
        m_busy      = 1;
        m_acked     = 0;
        m_addr      = a[m_slot];
        c_ack_cnt   = (k_ack >= 0) ? k_ack : int'($urandom_range(0, 3));
        c_rdy_delay = (k_rdy >= 0) ? k_rdy : int'($urandom_range(0, 4));
        c_data      = k_force ? k_data : DW'($urandom);
      end
      if (m_dl_prev && !downloading)
        for (int i = 0; i < SLOTS; i++) m_valid[i] = 0;
    end
    m_dl_prev = downloading;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_settle(input string tag, input int max);
    int n = 0;
    while (!settled() && n < max) begin
      tick();
      n++;
    end
    check(tag, 64'(settled()), 64'(1));
  endtask

  task automatic wait_acked(input string tag, input int max);
    int n = 0;
    while (!(m_busy && m_acked) && n < max) begin
      tick();
      n++;
    end
    check(tag, 64'(m_busy && m_acked), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] exp_rr [5];
    int dl_len;

    rst = 1; loop_rst = 0; downloading = 0; slot_cs = '0;
    for (int i = 0; i < SLOTS; i++) a[i] = '0;
    k_ack = -1; k_rdy = -1; k_force = 0; k_data = '0;
    model_reset();
    drive();
    @(negedge clk);
    check("rst_req", 64'(sdram_req), 64'(0));
    check("rst_addr", 64'(sdram_addr), 64'(0));
    check("rst_refresh", 64'(refresh_en), 64'(1));
    check("rst_ok", 64'(slot_ok), 64'(0));
    check("rst_dout", 64'(slot_dout[63:0] | slot_dout[127:64]), 64'(0));
    @(negedge clk);
    rst = 0;

    // Round-robin: all slots miss from reset, then slot 0 moves
    for (int i = 0; i < SLOTS; i++) begin
      a[i]      = 22'h0A0000 + AW'(i * 16);
      exp_rr[i] = a[i];
    end
    slot_cs = '1;
    iss_q.delete();
    wait_settle("rr_settle", 200);
    a[0] = 22'h0A1000;
    exp_rr[4] = a[0];
    wait_settle("rr_settle2", 100);
    check("rr_count", 64'(iss_q.size()), 64'(5));
    for (int j = 0; j < 5 && j < iss_q.size(); j++)
      check("rr_order", 64'(iss_q[j]), 64'(exp_rr[j]));

    // Single miss on slot 1, then a hit on the same word
    slot_cs = 4'b0010;
    a[1] = 22'h012345;
    k_ack = 2; k_rdy = 4; k_force = 1; k_data = 32'hDEADBEEF;
    iss_q.delete();
    wait_settle("miss_settle", 40);
    check("miss_issue", 64'(iss_q.size() > 0 ? iss_q[0] : '0), 64'(22'h012345));
    check("miss_ok", 64'(slot_ok[1]), 64'(1));
    check("miss_dout", 64'(slot_dout[63:32]), 64'(32'hDEADBEEF));
    k_force = 0;
    for (int n = 0; n < 3; n++) tick();
    check("hit_req", 64'(sdram_req), 64'(0));
    check("hit_refresh", 64'(refresh_en), 64'(1));
    check("hit_ok", 64'(slot_ok[1]), 64'(1));

    // Address change while slot 2's access is in flight
    k_ack = 1; k_rdy = 5;
    slot_cs = 4'b0100;
    a[2] = 22'h100;
    iss_q.delete();
    wait_acked("chg_ack", 20);
    a[2] = 22'h200;
    while (m_busy) tick();
    a[2] = 22'h100;
    drive(); #1;
    check("chg_tag_old", 64'(slot_ok[2]), 64'(1));
    tick();
    a[2] = 22'h200;
    drive(); #1;
    check("chg_ok_new", 64'(slot_ok[2]), 64'(0));
    wait_settle("chg_settle", 40);
    check("chg_count", 64'(iss_q.size()), 64'(2));
    check("chg_second", 64'(iss_q.size() > 1 ? iss_q[1] : '0), 64'(22'h200));

    // loop_rst in WAIT_RDY with a late data_rdy
    k_ack = 0; k_rdy = 6;
    slot_cs = 4'b0001;
    a[0] = 22'h3ABCD;
    iss_q.delete();
    wait_acked("lr_ack", 20);
    tick();
    loop_rst = 1;
    tick();
    loop_rst = 0;
    slot_cs = '0;
    drive(); #1;
    check("lr_req", 64'(sdram_req), 64'(0));
    for (int n = 0; n < 8; n++) tick();
    slot_cs = '1;
    drive(); #1;
    check("lr_ok", 64'(slot_ok), 64'(0));
    k_ack = -1; k_rdy = -1;
    wait_settle("lr_settle", 200);
    check("lr_refetch", 64'(iss_q.size()), 64'(5));

    // downloading blocks issue and invalidates on its falling edge
    downloading = 1;
    a[3] = 22'h2F0F0;
    slot_cs = 4'b1000;
    iss_q.delete();
    for (int n = 0; n < 6; n++) tick();
    check("dl_noreq", 64'(iss_q.size()), 64'(0));
    downloading = 0;
    tick();
    tick();
    slot_cs = '1;
    drive(); #1;
    check("dl_invalid", 64'(slot_ok[2:0]), 64'(0));
    wait_settle("dl_settle", 200);
    check("dl_first", 64'(iss_q.size() > 0 ? iss_q[0] : '0), 64'(22'h2F0F0));
    check("dl_count", 64'(iss_q.size()), 64'(4));

    // Random traffic
    dl_len = 0;
    for (int n = 0; n < 1200; n++) begin
      for (int i = 0; i < SLOTS; i++) begin
        if ($urandom_range(0, 7) == 0) slot_cs[i] = ~slot_cs[i];
        if ($urandom_range(0, 9) == 0) a[i] = {2'(i), 20'($urandom_range(0, 3))};
      end
      if (dl_len > 0) begin
        dl_len--;
        if (dl_len == 0) downloading = 0;
      end else if ($urandom_range(0, 149) == 0) begin
        downloading = 1;
        dl_len = int'($urandom_range(1, 6));
      end
      loop_rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    loop_rst = 0; downloading = 0;
    wait_settle("rand_settle", 200);

    // Asynchronous reset in the middle of a transaction
    k_ack = 5;
    slot_cs = 4'b0001;
    a[0] = 22'h155555;
    while (!(m_busy && !m_acked)) tick();
    tick();
    rst = 1;
    #1;
    check("arst_req", 64'(sdram_req), 64'(0));
    check("arst_addr", 64'(sdram_addr), 64'(0));
    check("arst_ok", 64'(slot_ok), 64'(0));
    check("arst_dout", 64'(slot_dout[63:0] | slot_dout[127:64]), 64'(0));
    model_reset();
    slot_cs = '0;
    @(negedge clk);
    rst = 0;
    k_ack = -1;
    for (int n = 0; n < 4; n++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
